// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling; rx_done/frame_err pulse one clk after the mid-stop-bit sample.
// No backpressure: each good byte overwrites rx_data and is announced by a single rx_done pulse.
module uart_receiver #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nx;
  logic            rx_meta, rx_sync, rx_prev;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [3:0]      sample_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
  logic            clr_cnt, clr_sample, shift_en, load_data, err_set;

  // rx_prev lags rx_sync by one clk so a falling edge is prev=1, sync=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign tick    = (tick_cnt == TW'(TICK_DIV - 1));
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_cnt    = 1'b0;
    clr_sample = 1'b0;
    shift_en   = 1'b0;
    load_data  = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_nx = START;
          clr_cnt  = 1'b1;
        end
      end
      START: begin
        if (tick && sample_cnt == 4'd7) begin
          if (!rx_sync) begin
            state_nx   = DATA;
            clr_sample = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      DATA: begin
        if (tick && sample_cnt == 4'd15) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
          end
        end
      end
      STOP: begin
        if (tick && sample_cnt == 4'd15) begin
          // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
          state_nx = IDLE;
          if (rx_sync) begin
            load_data = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt   <= '0;
      sample_cnt <= 4'd0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'h00;
    end else begin
      if (clr_cnt || tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      if (clr_cnt || clr_sample) begin
        sample_cnt <= 4'd0;
      end else if (tick) begin
        sample_cnt <= sample_cnt + 4'd1;
      end

      if (clr_cnt) begin
        bit_idx <= 3'd0;
      end else if (shift_en) begin
        bit_idx   <= bit_idx + 3'd1;
        shift_reg <= {rx_sync, shift_reg[7:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= load_data;
      frame_err <= err_set;
      if (load_data) begin
        rx_data <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 160 clks/bit: good, back-to-back, framing-error,
// glitch and reset-abort frames, with pulses counted by a free-running monitor.
module tb_uart_receiver;

  localparam int BIT_CLKS = 160;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  int         vec_cnt;
  int         miscomp_cnt;

  int         done_cnt;
  int         err_cnt;
  int         both_cnt;
  int         done_run;
  int         max_done_run;
  logic [7:0] data_log [16];

  uart_receiver #(
    .CLK_FREQ(1600000),
    .BAUD    (10000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done) begin
      data_log[done_cnt[3:0]] <= rx_data;
      done_cnt <= done_cnt + 1;
      done_run <= done_run + 1;
      if (done_run + 1 > max_done_run) max_done_run <= done_run + 1;
    end else begin
      done_run <= 0;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (rx_done && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscomp_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (BIT_CLKS - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vec_cnt      = 0;
    miscomp_cnt  = 0;
    done_cnt     = 0;
    err_cnt      = 0;
    both_cnt     = 0;
    done_run     = 0;
    max_done_run = 0;
    reset        = 1'b1;
    rx           = 1'b1;

    repeat (5) @(negedge clk);
    check_vec("rst_data",  32'(rx_data),   32'h00);
    check_vec("rst_done",  32'(rx_done),   32'h0);
    check_vec("rst_ferr",  32'(frame_err), 32'h0);
    check_vec("rst_busy",  32'(rx_busy),   32'h0);
    reset = 1'b0;
    idle(50);

    // Single good frame with busy window probes.
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (20) @(negedge clk);
        check_vec("a5_busy_start", 32'(rx_busy), 32'h1);
        repeat (9 * BIT_CLKS + 20 - 20) @(negedge clk);
        check_vec("a5_busy_stop", 32'(rx_busy), 32'h1);
      end
    join
    check_vec("a5_busy_after", 32'(rx_busy),      32'h0);
    check_vec("a5_done_cnt",   32'(done_cnt),     32'd1);
    check_vec("a5_data",       32'(rx_data),      32'hA5);
    check_vec("a5_log",        32'(data_log[0]),  32'hA5);
    check_vec("a5_ferr_cnt",   32'(err_cnt),      32'd0);
    check_vec("a5_pulse_w",    32'(max_done_run), 32'd1);
    idle(100);

    // Back-to-back frames with no idle gap.
    send_frame(8'h3C, 1'b1);
    check_vec("b2b_first", 32'(rx_data), 32'h3C);
    send_frame(8'hC3, 1'b1);
    check_vec("b2b_done_cnt", 32'(done_cnt),    32'd3);
    check_vec("b2b_log0",     32'(data_log[1]), 32'h3C);
    check_vec("b2b_log1",     32'(data_log[2]), 32'hC3);
    check_vec("b2b_data",     32'(rx_data),     32'hC3);
    idle(100);

    // Glitch shorter than half a bit must be rejected in START.
    @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check_vec("glitch_busy", 32'(rx_busy), 32'h1);
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (150) @(negedge clk);
    check_vec("glitch_idle",  32'(rx_busy),  32'h0);
    check_vec("glitch_done",  32'(done_cnt), 32'd3);
    check_vec("glitch_ferr",  32'(err_cnt),  32'd0);

    // Bad stop bit, then the line stays low for three frame times.
    send_frame(8'hFF, 1'b0);
    check_vec("ferr_cnt",  32'(err_cnt),  32'd1);
    check_vec("ferr_done", 32'(done_cnt), 32'd3);
    check_vec("ferr_data", 32'(rx_data),  32'hC3);
    repeat (3 * 10 * BIT_CLKS) @(negedge clk);
    check_vec("low_busy", 32'(rx_busy),  32'h0);
    check_vec("low_ferr", 32'(err_cnt),  32'd1);
    check_vec("low_done", 32'(done_cnt), 32'd3);
    idle(200);
    send_frame(8'h5A, 1'b1);
    check_vec("recover_done", 32'(done_cnt), 32'd4);
    check_vec("recover_data", 32'(rx_data),  32'h5A);
    idle(100);

    // Reset lands in data bit 3 of 0x81 and releases in bit 7 (line high).
    fork
      send_frame(8'h81, 1'b1);
      begin
        repeat (4 * BIT_CLKS + 80) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_vec("abort_rst_data", 32'(rx_data), 32'h00);
        check_vec("abort_rst_busy", 32'(rx_busy), 32'h0);
        repeat (8 * BIT_CLKS + 40 - (4 * BIT_CLKS + 81)) @(negedge clk);
        reset = 1'b0;
      end
    join
    idle(100);
    check_vec("abort_busy", 32'(rx_busy),  32'h0);
    check_vec("abort_done", 32'(done_cnt), 32'd4);
    check_vec("abort_ferr", 32'(err_cnt),  32'd1);
    check_vec("abort_data", 32'(rx_data),  32'h00);
    send_frame(8'h42, 1'b1);
    idle(20);
    check_vec("post_rst_done", 32'(done_cnt),     32'd5);
    check_vec("post_rst_data", 32'(rx_data),      32'h42);
    check_vec("never_both",    32'(both_cnt),     32'd0);
    check_vec("pulse_w_final", 32'(max_done_run), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscomp_cnt);
    $finish;
  end

endmodule
